fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/copperv_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/copperv_pkg.sv
// Shared constants and helpers for the copperv instruction fetch path.
package copperv_pkg;

    localparam int unsigned PC_STEP = 4;

    // One buffered fetch entry carries the word together with its PC.
    function automatic int unsigned fetch_entry_width(input int unsigned pc_w,
                                                      input int unsigned bus_w);
        return pc_w + bus_w;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, word} entries; flush empties it in one cycle.
module fetch_fifo
    import copperv_pkg::*;
#(
    parameter int unsigned width = 64,
    parameter int unsigned depth = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [width-1:0]             push_data,
    input  logic                         pop,
    output logic [width-1:0]             pop_data,
    output logic [$clog2(depth):0]       count
);

    localparam int unsigned AW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full, empty, push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(depth));
    assign empty = (count_q == '0);

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited sequential requests on the i-bus, in-order
// responses buffered with their PCs, redirect flushes and discards stale responses.
module fetch_unit
    import copperv_pkg::*;
#(
    parameter int unsigned           bus_width  = 32,
    parameter int unsigned           pc_width   = 32,
    parameter logic [pc_width-1:0]   pc_init    = '0,
    parameter int unsigned           fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  i_raddr_valid,
    input  logic                  i_raddr_ready,
    output logic [bus_width-1:0]  i_raddr,
    input  logic                  i_rdata_valid,
    output logic                  i_rdata_ready,
    input  logic [bus_width-1:0]  i_rdata,
    input  logic                  redirect_valid,
    input  logic [pc_width-1:0]   redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [bus_width-1:0]  instr,
    output logic [pc_width-1:0]   instr_pc
);

    localparam int unsigned CW = $clog2(fifo_depth) + 1;
    localparam int unsigned EW = fetch_entry_width(pc_width, bus_width);

    logic [pc_width-1:0] fetch_pc_q, fetch_pc_d;
    logic [pc_width-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [CW-1:0]       discard_q, discard_d;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         credit_used;
    logic [pc_width-1:0] redirect_aligned;
    logic [EW-1:0]       push_entry, head_entry;
    logic                raddr_hs, rdata_hs, push, pop;

    assign redirect_aligned = redirect_pc & ~pc_width'(3);

    assign credit_used   = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign i_raddr_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(fifo_depth));
    assign i_raddr       = bus_width'(fetch_pc_q);
    assign i_rdata_ready = !rst;

    assign raddr_hs = i_raddr_valid && i_raddr_ready;
    assign rdata_hs = i_rdata_valid && i_rdata_ready;

    assign push        = rdata_hs && !redirect_valid && (discard_q == '0);
    assign instr_valid = !rst && !redirect_valid && (fifo_count != '0);
    assign pop         = instr_valid && instr_ready;

    // resp_pc follows the request stream: responses return in order, so the
    // PC of the next kept response is the redirect target plus kept words * 4.
    assign push_entry = {resp_pc_q, i_rdata};
    assign {instr_pc, instr} = head_entry;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + CW'(raddr_hs) - CW'(rdata_hs);
        if (redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            discard_d  = inflight_q - CW'(rdata_hs);
        end else begin
            if (raddr_hs) fetch_pc_d = fetch_pc_q + pc_width'(PC_STEP);
            if (rdata_hs) begin
                if (discard_q != '0) discard_d = discard_q - CW'(1);
                else                 resp_pc_d = resp_pc_q + pc_width'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= pc_init;
            resp_pc_q  <= pc_init;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .width (EW),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: 1-cycle-latency i-bus slave model plus a
// scoreboard queue of expected {pc, word} pairs checked by an output monitor.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_raddr_valid, i_raddr_ready;
    logic [31:0] i_raddr;
    logic        i_rdata_valid, i_rdata_ready;
    logic [31:0] i_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .bus_width  (32),
        .pc_width   (32),
        .pc_init    (32'h0000_0100),
        .fifo_depth (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_raddr_valid  (i_raddr_valid),
        .i_raddr_ready  (i_raddr_ready),
        .i_raddr        (i_raddr),
        .i_rdata_valid  (i_rdata_valid),
        .i_rdata_ready  (i_rdata_ready),
        .i_rdata        (i_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      exp_q[$];
    logic [31:0] pending[$];
    logic [31:0] addr_log[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pops   = 0;
    logic        slave_ready;
    logic        resp_en;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] log_at(input int unsigned i);
        return (addr_log.size() > i) ? addr_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_run(input logic [31:0] start, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            entry_t e;
            e.pc   = start + 32'(i) * 32'd4;
            e.data = data_of(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; holds redirect for exactly one cycle.
    task automatic redirect_to(input logic [31:0] target, input logic [31:0] raw,
                               input int unsigned n);
        exp_q.delete();
        addr_log.delete();
        expect_run(target, n);
        redirect_valid = 1'b1;
        redirect_pc    = raw;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    // Slave: drives at negedge+1, observes handshakes at negedge+3.
    initial begin
        i_raddr_ready = 1'b0;
        i_rdata_valid = 1'b0;
        i_rdata       = '0;
        forever begin
            @(negedge clk);
            #1;
            i_raddr_ready = slave_ready;
            i_rdata_valid = resp_en && (pending.size() > 0);
            i_rdata       = (pending.size() > 0) ? data_of(pending[0]) : 32'h0;
            #2;
            if (rst) begin
                pending.delete();
            end else begin
                if (i_rdata_valid && i_rdata_ready) void'(pending.pop_front());
                if (i_raddr_valid && i_raddr_ready) begin
                    pending.push_back(i_raddr);
                    addr_log.push_back(i_raddr);
                end
            end
        end
    end

    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && instr_valid && instr_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL instr_unexpected actual_pc=%h required=none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instr", instr, e.data);
                end
            end
        end
    end

    initial begin
        int unsigned p0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        slave_ready    = 1'b1;
        resp_en        = 1'b1;

        cyc(3);
        #4;
        check("rst_raddr_valid", 32'(i_raddr_valid), 32'd0);
        check("rst_rdata_ready", 32'(i_rdata_ready), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);

        // Reset release from pc_init, free-running stream.
        cyc(1);
        addr_log.delete();
        expect_run(32'h100, 16);
        rst = 1'b0;
        cyc(8);
        check("first_raddr", log_at(0), 32'h100);
        check("second_raddr", log_at(1), 32'h104);
        check("third_raddr", log_at(2), 32'h108);

        // Back-to-back throughput from PC 0.
        redirect_to(32'h0, 32'h0, 24);
        cyc(5);
        p0 = pops;
        cyc(10);
        check("no_gap_pops", 32'(pops - p0), 32'd10);

        // Consumer stalled: credits stop requests after fifo_depth.
        instr_ready = 1'b0;
        redirect_to(32'h400, 32'h400, 24);
        cyc(9);
        #4;
        check("stall_req_count", 32'(addr_log.size()), 32'd4);
        check("stall_raddr_valid", 32'(i_raddr_valid), 32'd0);
        check("stall_raddr0", log_at(0), 32'h400);
        check("stall_raddr3", log_at(3), 32'h40C);

        // Drain from full with an intermittent consumer.
        p0 = pops;
        for (int i = 0; i < 24; i++) begin
            cyc(1);
            instr_ready = (i % 2 == 0);
        end
        check("alt_pops", 32'(pops - p0), 32'd12);

        // Two requests outstanding, then redirect to an unaligned target.
        cyc(1);
        slave_ready = 1'b0;
        instr_ready = 1'b1;
        cyc(4);
        resp_en     = 1'b0;
        slave_ready = 1'b1;
        redirect_to(32'h1000, 32'h1000, 0);
        cyc(2);
        slave_ready = 1'b0;
        #4;
        check("hold_raddr_a", i_raddr, 32'h1008);
        check("hold_valid_a", 32'(i_raddr_valid), 32'd1);
        cyc(1);
        #4;
        check("hold_raddr_b", i_raddr, 32'h1008);
        cyc(1);
        resp_en     = 1'b1;
        slave_ready = 1'b1;
        redirect_to(32'h2000, 32'h2002, 16);
        #4;
        check("flush_empty_a", 32'(instr_valid), 32'd0);
        cyc(1);
        #4;
        check("flush_empty_b", 32'(instr_valid), 32'd0);
        cyc(8);

        // PC wraparound at the top of the address space.
        redirect_to(32'hFFFF_FFF8, 32'hFFFF_FFF8, 16);
        cyc(8);
        check("wrap_raddr0", log_at(0), 32'hFFFF_FFF8);
        check("wrap_raddr1", log_at(1), 32'hFFFF_FFFC);
        check("wrap_raddr2", log_at(2), 32'h0);

        // Reset mid-stream.
        rst = 1'b1;
        #4;
        check("rst2_raddr_valid", 32'(i_raddr_valid), 32'd0);
        check("rst2_rdata_ready", 32'(i_rdata_ready), 32'd0);
        check("rst2_instr_valid", 32'(instr_valid), 32'd0);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
